// File: rtl/reg_arbiter4.sv
// rtl/reg_arbiter4.sv - four-source round-robin arbiter driving the RegMux4 Select bus
// Grants are held until release, requester drop, or hold-limit expiry.
module reg_arbiter4 #(
  parameter int BUS_WIDTH  = 2,
  parameter int HOLD_LIMIT = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [3:0]           Request,
  input  logic                 Release,
  output logic [BUS_WIDTH-1:0] Select,
  output logic [3:0]           Grant,
  output logic                 Busy
);

  localparam int CNT_W = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_LIMIT > 0) ? CNT_W'(HOLD_LIMIT - 1) : '0;

  typedef enum logic {IDLE, GRANTED} stateT;

  stateT                state, stateNext;
  logic [BUS_WIDTH-1:0] lastPtr, lastNext;
  logic [BUS_WIDTH-1:0] searchBase, candIdx, winIdx, selectNext;
  logic                 winFound;
  logic [CNT_W-1:0]     holdCnt, cntNext;
  logic [3:0]           grantNext;
  logic                 busyNext;
  logic                 holdExpired, grantEnd;

  // While granted, the search starts after the current owner so it only wins again when alone.
  assign searchBase  = (state == GRANTED) ? Select : lastPtr;
  assign holdExpired = (HOLD_LIMIT != 0) && (holdCnt == CNT_LAST);
  assign grantEnd    = Release || !Request[Select] || holdExpired;

  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    candIdx  = '0;
    for (int i = 1; i <= 4; i++) begin
      candIdx = searchBase + BUS_WIDTH'(i);
      if (!winFound && Request[candIdx]) begin
        winFound = 1'b1;
        winIdx   = candIdx;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    selectNext = Select;
    grantNext  = Grant;
    busyNext   = Busy;
    cntNext    = holdCnt;
    lastNext   = lastPtr;
    case (state)
      IDLE: begin
        if (winFound) begin
          stateNext  = GRANTED;
          selectNext = winIdx;
          grantNext  = 4'b0001 << winIdx;
          busyNext   = 1'b1;
          cntNext    = '0;
        end
      end
      GRANTED: begin
        if (grantEnd) begin
          lastNext = Select;
          if (winFound) begin
            selectNext = winIdx;
            grantNext  = 4'b0001 << winIdx;
            busyNext   = 1'b1;
            cntNext    = '0;
          end else begin
            stateNext = IDLE;
            grantNext = 4'b0000;
            busyNext  = 1'b0;
          end
        end else begin
          cntNext = holdCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      Select  <= '0;
      Grant   <= 4'b0000;
      Busy    <= 1'b0;
      holdCnt <= '0;
      lastPtr <= BUS_WIDTH'(3);
    end else begin
      state   <= stateNext;
      Select  <= selectNext;
      Grant   <= grantNext;
      Busy    <= busyNext;
      holdCnt <= cntNext;
      lastPtr <= lastNext;
    end
  end

endmodule

// File: tb/tb_reg_arbiter4.sv
// tb/tb_reg_arbiter4.sv - self-checking bench for reg_arbiter4 with a behavioural model
module tb_reg_arbiter4;

  localparam int HOLD = 8;

  logic       Clk;
  logic       Reset;
  logic [3:0] Request;
  logic       Release;
  logic [1:0] Select;
  logic [3:0] Grant;
  logic       Busy;

  int nChecks = 0;
  int nFails  = 0;

  int muxData [4] = '{42, 15, 2, 0};
  int muxOut;

  int mOwner, mSel, mLast, mCnt;

  reg_arbiter4 #(.BUS_WIDTH(2), .HOLD_LIMIT(HOLD)) dut (
    .Clk(Clk), .Reset(Reset), .Request(Request), .Release(Release),
    .Select(Select), .Grant(Grant), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign muxOut = muxData[Select];

  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] expGrant();
    return (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
  endfunction

  task automatic modelUpdate(input logic [3:0] r, input logic l, input logic s);
    if (s) begin
      mOwner = -1; mSel = 0; mLast = 3; mCnt = 0;
    end else if (mOwner < 0) begin
      if (r != 4'b0000) begin
        mOwner = pick(r, mLast); mSel = mOwner; mCnt = 0;
      end
    end else if (l || !r[mOwner] || (HOLD != 0 && mCnt == HOLD - 1)) begin
      mLast = mOwner;
      if (r != 4'b0000) begin
        mOwner = pick(r, mLast); mSel = mOwner; mCnt = 0;
      end else begin
        mOwner = -1;
      end
    end else begin
      mCnt++;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic l, input logic s);
    Request = r; Release = l; Reset = s;
    @(posedge Clk);
    modelUpdate(r, l, s);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(4'b1111, 1'b0, 1'b1);
      nChecks++;
      if ({Grant, Select, Busy} !== {4'b0000, 2'd0, 1'b0}) begin
        nFails++;
        $display("FAIL reset: Grant=%b Select=%0d Busy=%b, expected 0000/0/0", Grant, Select, Busy);
      end
    end
    step(4'b1111, 1'b0, 1'b0);
    nChecks++;
    if ({Grant, Select, Busy} !== {4'b0001, 2'd0, 1'b1} || muxOut != 42) begin
      nFails++;
      $display("FAIL first_grant: Grant=%b Select=%0d Busy=%b mux=%0d, expected 0001/0/1/42",
               Grant, Select, Busy, muxOut);
    end
  endtask

  task automatic test_release_rotation();
    int expSel [4] = '{1, 2, 3, 0};
    int expMux [4] = '{15, 2, 0, 42};
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      nChecks++;
      if (Select !== 2'(expSel[i]) || Busy !== 1'b1 || Grant !== 4'(1 << expSel[i]) || muxOut != expMux[i]) begin
        nFails++;
        $display("FAIL rotation[%0d]: Select=%0d Grant=%b Busy=%b mux=%0d, expected Select=%0d mux=%0d",
                 i, Select, Grant, Busy, muxOut, expSel[i], expMux[i]);
      end
    end
  endtask

  task automatic test_hold_limit();
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    for (int k = 1; k < HOLD; k++) begin
      step(4'b1111, 1'b0, 1'b0);
      nChecks++;
      if (Select !== 2'd0 || Grant !== 4'b0001) begin
        nFails++;
        $display("FAIL hold_keep[%0d]: Select=%0d Grant=%b, expected 0/0001", k, Select, Grant);
      end
    end
    step(4'b1111, 1'b0, 1'b0);
    nChecks++;
    if (Select !== 2'd1 || Grant !== 4'b0010 || Busy !== 1'b1) begin
      nFails++;
      $display("FAIL hold_rotate: Select=%0d Grant=%b Busy=%b, expected 1/0010/1", Select, Grant, Busy);
    end
  endtask

  task automatic test_single_requester();
    step(4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 3 * HOLD; k++) begin
      step(4'b0100, 1'b0, 1'b0);
      nChecks++;
      if (Select !== 2'd2 || Grant !== 4'b0100 || Busy !== 1'b1) begin
        nFails++;
        $display("FAIL single_regrant[%0d]: Select=%0d Grant=%b Busy=%b, expected 2/0100/1",
                 k, Select, Grant, Busy);
      end
    end
  endtask

  task automatic test_drop();
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b0);
    nChecks++;
    if (Select !== 2'd1 || Grant !== 4'b0010) begin
      nFails++;
      $display("FAIL drop_owner1: Select=%0d Grant=%b, expected 1/0010", Select, Grant);
    end
    step(4'b1000, 1'b0, 1'b0);
    nChecks++;
    if (Select !== 2'd3 || Grant !== 4'b1000 || Busy !== 1'b1) begin
      nFails++;
      $display("FAIL drop_handover: Select=%0d Grant=%b Busy=%b, expected 3/1000/1", Select, Grant, Busy);
    end
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 1'b1, 1'b0);
      nChecks++;
      if (Select !== 2'd3 || Grant !== 4'b0000 || Busy !== 1'b0 || muxOut != 0) begin
        nFails++;
        $display("FAIL drop_idle[%0d]: Select=%0d Grant=%b Busy=%b, expected 3/0000/0", k, Select, Grant, Busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    nChecks++;
    if (Select !== 2'd2) begin
      nFails++;
      $display("FAIL mid_setup: Select=%0d, expected 2", Select);
    end
    step(4'b1111, 1'b0, 1'b1);
    nChecks++;
    if ({Grant, Select, Busy} !== {4'b0000, 2'd0, 1'b0}) begin
      nFails++;
      $display("FAIL mid_reset: Grant=%b Select=%0d Busy=%b, expected 0000/0/0", Grant, Select, Busy);
    end
    step(4'b1111, 1'b0, 1'b0);
    nChecks++;
    if (Grant !== 4'b0001 || Select !== 2'd0) begin
      nFails++;
      $display("FAIL mid_regrant: Grant=%b Select=%0d, expected 0001/0", Grant, Select);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    r = 4'b0000;
    step(4'b0000, 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
      nChecks++;
      if (Grant !== expGrant() || Select !== 2'(mSel) || Busy !== (mOwner >= 0)) begin
        nFails++;
        $display("FAIL random[%0d]: req=%b rel=%b rst=%b Grant=%b Select=%0d Busy=%b, expected Grant=%b Select=%0d Busy=%b",
                 n, Request, Release, Reset, Grant, Select, Busy, expGrant(), mSel, mOwner >= 0);
      end
      nChecks++;
      if (!(Grant == 4'b0000 || Grant == 4'(1 << Select)) || Busy !== (|Grant)) begin
        nFails++;
        $display("FAIL invariant[%0d]: Grant=%b Select=%0d Busy=%b, expected Grant 0 or onehot(Select), Busy=|Grant",
                 n, Grant, Select, Busy);
      end
    end
  endtask

  initial begin
    Request = 4'b0000;
    Release = 1'b0;
    Reset   = 1'b1;
    mOwner = -1; mSel = 0; mLast = 3; mCnt = 0;
    test_reset();
    test_release_rotation();
    test_hold_limit();
    test_single_requester();
    test_drop();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
